// File: rtl/registro_digitos_vga.sv
// registro_digitos_vga: shadowed BCD digit bank committed on vsync, with blinking field/alarm flags
module registro_digitos_vga #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] addr,
    input  logic [7:0] data_in,
    input  logic       vsync,
    input  logic [3:0] campo_sel,
    input  logic       ring_in,
    output logic [3:0] hora1,
    output logic [3:0] hora2,
    output logic [3:0] min1,
    output logic [3:0] min2,
    output logic [3:0] sec1,
    output logic [3:0] sec2,
    output logic [3:0] dia1,
    output logic [3:0] dia2,
    output logic [3:0] mes1,
    output logic [3:0] mes2,
    output logic [3:0] ano1,
    output logic [3:0] ano2,
    output logic [3:0] ch1,
    output logic [3:0] ch2,
    output logic [3:0] cm1,
    output logic [3:0] cm2,
    output logic [3:0] cs1,
    output logic [3:0] cs2,
    output logic       bandera_Hhora,
    output logic       bandera_Mhora,
    output logic       bandera_Shora,
    output logic       bandera_Dfecha,
    output logic       bandera_Mfecha,
    output logic       bandera_Afecha,
    output logic       bandera_Hcrono,
    output logic       bandera_Mcrono,
    output logic       bandera_Scrono,
    output logic       activring,
    output logic       wr_err
);
    logic [7:0] shadow [9];
    logic [7:0] disp [9];
    logic       pending, vsync_d, blink_phase, phase_nxt, fe, wr_ok, sel_chg;
    logic [7:0] frame_cnt;
    logic [3:0] campo_d;
    logic [8:0] flags;

    assign fe        = vsync_d & ~vsync;
    assign wr_ok     = wr_en && addr <= 4'd8 && data_in[7:4] <= 4'd9 && data_in[3:0] <= 4'd9;
    assign sel_chg   = campo_sel != campo_d;
    assign phase_nxt = sel_chg ? 1'b1 : (fe && frame_cnt == 8'(BLINK_FRAMES - 1)) ? ~blink_phase : blink_phase;

    // Shadow writes, frame-synchronous commit to the displayed digits, and rejected-write pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 9; i++) begin
                shadow[i] <= '0;
                disp[i]   <= '0;
            end
            pending <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (fe && pending) disp[i] <= shadow[i];
                if (wr_ok && addr == 4'(i)) shadow[i] <= data_in;
            end
            pending <= wr_ok | (pending & ~fe);
            wr_err  <= wr_en & ~wr_ok;
        end
    end

    // Frame-counted blink timer, restarted with a full on-period whenever the edited field changes
    always_ff @(posedge clk) begin
        if (!reset) begin
            vsync_d     <= 1'b1;
            campo_d     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
            flags       <= '0;
            activring   <= 1'b0;
        end else begin
            vsync_d     <= vsync;
            campo_d     <= campo_sel;
            frame_cnt   <= sel_chg ? 8'd0 : !fe ? frame_cnt : (frame_cnt == 8'(BLINK_FRAMES - 1)) ? 8'd0 : frame_cnt + 8'd1;
            blink_phase <= phase_nxt;
            flags       <= (campo_sel >= 4'd1 && campo_sel <= 4'd9 && phase_nxt) ? 9'b1 << (campo_sel - 4'd1) : 9'b0;
            activring   <= ring_in & phase_nxt;
        end
    end

    assign {hora1, hora2} = disp[0];
    assign {min1, min2}   = disp[1];
    assign {sec1, sec2}   = disp[2];
    assign {dia1, dia2}   = disp[3];
    assign {mes1, mes2}   = disp[4];
    assign {ano1, ano2}   = disp[5];
    assign {ch1, ch2}     = disp[6];
    assign {cm1, cm2}     = disp[7];
    assign {cs1, cs2}     = disp[8];
    assign {bandera_Scrono, bandera_Mcrono, bandera_Hcrono, bandera_Afecha, bandera_Mfecha,
            bandera_Dfecha, bandera_Shora, bandera_Mhora, bandera_Hhora} = flags;
endmodule
